gio_outbank: RTL and testbench
==============================

GIO_OUTBANK -- requirements
Module: gio_outbank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, meaning the bank base address; it is 256-byte aligned.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning the number of output channels (1..8).
REQ-003 SHALL have parameter WIDTH, default 8, meaning the bits per channel (1..32).
REQ-004 SHALL have parameter PULSE_CYCLES, default 16, meaning the one-shot pulse length in clocks (1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port mem_valid, input, 1 bit: bus request valid.
REQ-008 SHALL have port mem_addr, input, 32 bits: byte address.
REQ-009 SHALL have port mem_wdata, input, 32 bits: write data.
REQ-010 SHALL have port mem_wstrb, input, 4 bits: byte write strobes; 0000 means read.
REQ-011 SHALL have port mem_ready, output, 1 bit: access acknowledge.
REQ-012 SHALL have port mem_rdata, output, 32 bits: read data.
REQ-013 SHALL have port odata, output, CHANNELS*WIDTH bits: port outputs, with channel c at bits [c*WIDTH +: WIDTH].

Function
REQ-014 SHALL decode a hit when mem_valid=1 and mem_addr[31:8]==BASE_ADDR[31:8]; channel = mem_addr[7:5], offset = mem_addr[4:0].
REQ-015 SHALL decode offsets as 0x00 DATA (rw), 0x04 SET (w), 0x08 CLR (w), 0x0C TGL (w), 0x10 PULSE (w) and 0x14 STATUS (r, bit0 = pulse busy).
- Channel index >= CHANNELS, any other offset, or a write to STATUS: acknowledge, read 0, write ignored.
REQ-016 SHALL run a two-state handshake FSM:
- IDLE -> ACK on a hit.
- ACK -> IDLE unconditionally.
- mem_ready=1 only in ACK, so it is a one-cycle pulse one clock after the hit.
- A hit is not re-accepted in the cycle after ACK even if mem_valid is still 1.
REQ-017 SHALL apply the write effect at the same edge that enters ACK; odata shows the new value while mem_ready=1.
REQ-018 SHALL register read data at the same edge; mem_rdata holds it zero-extended during ACK and is 0 in IDLE.
REQ-019 SHALL form the effective write mask M per byte: bit i is in M when mem_wstrb[i/8]=1; bits at or above WIDTH are ignored.
REQ-020 SHALL update registers on writes as follows:
- DATA: d = (d & ~M) | (wdata & M).
- SET: d |= wdata & M.
- CLR: d &= ~(wdata & M).
- TGL: d ^= wdata & M.
REQ-021 SHALL handle PULSE writes as follows:
- Set bits P = wdata & M in d.
- OR P into the channel pulse mask.
- Load the channel counter with PULSE_CYCLES.
- A retrigger while busy reloads the counter and extends all masked bits.
REQ-022 SHALL keep the channel busy while its counter is nonzero.
- Each clock the counter decrements.
- On the clock it goes 1 -> 0, the masked bits clear in d and the mask clears.
- Bits set by PULSE are therefore high for exactly PULSE_CYCLES clocks.
REQ-023 SHALL give a bus write precedence over expiry when both hit the same channel in the same cycle:
- Bits in M take the written result.
- Masked bits outside M clear.
- A same-cycle PULSE write takes the retrigger path.
REQ-024 SHALL apply any DATA/SET/CLR/TGL write to bits in M by also removing those bits from the pulse mask; they then become static.
REQ-025 SHALL run all channel counters independently and concurrently.
REQ-026 SHALL make reads side-effect free.

Reset
REQ-027 SHALL, while resetn=0, drive odata=0, all pulse masks=0, all counters=0, FSM=IDLE, mem_ready=0 and mem_rdata=0, asynchronously.
REQ-028 SHALL abort an in-flight access or pulse on reset mid-operation; no ack is issued and the first hit after deassertion is handled normally.

Verification
REQ-029 SHALL pass the write/read test: write 0xA5, wstrb 0001 to BASE+0x00 -> mem_ready for 1 cycle, one clock after valid; odata[7:0]=0xA5; a read of BASE+0x00 returns 0x000000A5.
REQ-030 SHALL pass the set/clear/toggle test with channel 1 = 0x0F:
- SET 0x30 -> 0x3F.
- CLR 0x03 -> 0x3C.
- TGL 0xFF -> 0xC3.
- Other channels unchanged.
REQ-031 SHALL pass the pulse test: PULSE 0x01 on channel 2 (PULSE_CYCLES=16) -> bit0 high for exactly 16 clocks; STATUS reads 1 during the pulse and 0 after; a retrigger at clock 10 extends the pulse to clock 26.
REQ-032 SHALL pass the collision test: SET 0x01 on the same channel at the expiry clock -> bit0 stays 1 and the mask is clear; a second scenario with CLR at expiry -> bit0 becomes 0.
REQ-033 SHALL pass the decode test:
- Access to channel 7 with CHANNELS=4 -> acked, read 0, no change.
- Address outside BASE[31:8] -> mem_ready stays 0.
- wstrb 0000 -> no write.
REQ-034 SHALL pass the reset test: assert resetn=0 mid-pulse and mid-ACK -> odata=0 and mem_ready=0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/gio_outbank.sv
// rtl/gio_outbank.sv - memory-mapped output bank with DATA/SET/CLR/TGL writes and per-channel one-shot pulses
module gio_outbank #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          CHANNELS     = 4,
  parameter int          WIDTH        = 8,
  parameter int          PULSE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mem_valid,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  output logic [CHANNELS*WIDTH-1:0] odata
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  localparam logic [4:0]  OFF_DATA   = 5'h00;
  localparam logic [4:0]  OFF_SET    = 5'h04;
  localparam logic [4:0]  OFF_CLR    = 5'h08;
  localparam logic [4:0]  OFF_TGL    = 5'h0C;
  localparam logic [4:0]  OFF_PULSE  = 5'h10;
  localparam logic [4:0]  OFF_STATUS = 5'h14;
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q  [CHANNELS];
  logic [WIDTH-1:0] data_d  [CHANNELS];
  logic [WIDTH-1:0] pmask_q [CHANNELS];
  logic [WIDTH-1:0] pmask_d [CHANNELS];
  logic [15:0]      cnt_q   [CHANNELS];
  logic [15:0]      cnt_d   [CHANNELS];
  logic [WIDTH-1:0] wr_res  [CHANNELS];
  logic             static_wr [CHANNELS];
  logic [31:0]      rdata_q, rdata_d;

  logic             hit;
  logic             is_write;
  logic [2:0]       ch;
  logic [4:0]       off;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic             unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_wmask
      assign wmask[i] = mem_wstrb[i/8];
    end
  endgenerate

  assign wbits        = mem_wdata[WIDTH-1:0] & wmask;
  assign unused_wdata = ^mem_wdata;
  assign ch           = mem_addr[7:5];
  assign off          = mem_addr[4:0];
  assign is_write     = |mem_wstrb;
  // The IDLE qualifier keeps a still-asserted request from being taken twice.
  assign hit = (state_q == IDLE) && mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : chan_next
    rdata_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      data_d[c]    = data_q[c];
      pmask_d[c]   = pmask_q[c];
      cnt_d[c]     = (cnt_q[c] != 16'd0) ? cnt_q[c] - 16'd1 : 16'd0;
      wr_res[c]    = data_q[c];
      static_wr[c] = 1'b0;
      if (cnt_q[c] == 16'd1) begin
        data_d[c]  = data_q[c] & ~pmask_q[c];
        pmask_d[c] = '0;
      end
      if (hit && (ch == 3'(c))) begin
        if (is_write) begin
          case (off)
            OFF_DATA: begin wr_res[c] = (data_q[c] & ~wmask) | wbits; static_wr[c] = 1'b1; end
            OFF_SET:  begin wr_res[c] = data_q[c] | wbits;            static_wr[c] = 1'b1; end
            OFF_CLR:  begin wr_res[c] = data_q[c] & ~wbits;           static_wr[c] = 1'b1; end
            OFF_TGL:  begin wr_res[c] = data_q[c] ^ wbits;            static_wr[c] = 1'b1; end
            // Retrigger path: overrides a same-cycle expiry and keeps existing pulse bits.
            OFF_PULSE: begin
              data_d[c]  = data_q[c] | wbits;
              pmask_d[c] = pmask_q[c] | wbits;
              cnt_d[c]   = PULSE_LOAD;
            end
            default: ;
          endcase
          if (static_wr[c]) begin
            data_d[c]  = (data_d[c] & ~wmask) | (wr_res[c] & wmask);
            pmask_d[c] = pmask_d[c] & ~wmask;
          end
        end else if (off == OFF_DATA) begin
          rdata_d = 32'(data_q[c]);
        end else if (off == OFF_STATUS) begin
          rdata_d = {31'd0, cnt_q[c] != 16'd0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdata_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        data_q[c]  <= '0;
        pmask_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      for (int c = 0; c < CHANNELS; c++) begin
        data_q[c]  <= data_d[c];
        pmask_q[c] <= pmask_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  assign mem_ready = (state_q == ACK);
  assign mem_rdata = rdata_q;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_odata
      assign odata[c*WIDTH +: WIDTH] = data_q[c];
    end
  endgenerate

endmodule

// File: tb/tb_gio_outbank.sv
// tb/tb_gio_outbank.sv - directed and randomized checks of gio_outbank against a timestamp-based pulse model
module tb_gio_outbank;

  localparam int          CH   = 4;
  localparam int          W    = 8;
  localparam int          PC   = 16;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wstrb = '0;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [CH*W-1:0] odata;

  gio_outbank #(.BASE_ADDR(BASE), .CHANNELS(CH), .WIDTH(W), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .odata(odata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0;

  // Pulse bits are modelled by the absolute clock number at which they drop.
  logic [W-1:0] m_data [CH];
  logic [W-1:0] m_mask [CH];
  int           m_end  [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_data[c] = '0; m_mask[c] = '0; m_end[c] = 0;
    end
  endfunction

  function automatic void settle(input int upto);
    for (int c = 0; c < CH; c++)
      if (m_end[c] != 0 && m_end[c] <= upto) begin
        m_data[c] = m_data[c] & ~m_mask[c];
        m_mask[c] = '0;
        m_end[c]  = 0;
      end
  endfunction

  function automatic logic [31:0] exp_od();
    logic [31:0] v = '0;
    for (int c = 0; c < CH; c++) v[c*W +: W] = m_data[c];
    return v;
  endfunction

  function automatic void model_access(input int e, input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [3:0] ws, output logic [31:0] rd);
    int c;
    logic [4:0]   off;
    logic [W-1:0] m, p, old, wr;
    settle(e - 1);
    rd  = '0;
    c   = int'(addr[7:5]);
    off = addr[4:0];
    if (c >= CH) begin settle(e); return; end
    m = ws[0] ? 8'hFF : 8'h00;
    p = wd[7:0] & m;
    if (ws == 4'b0000) begin
      if (off == 5'h00) rd = {24'd0, m_data[c]};
      if (off == 5'h14) rd = (m_end[c] != 0) ? 32'd1 : 32'd0;
      settle(e);
      return;
    end
    if (off == 5'h10) begin
      m_data[c] = m_data[c] | p;
      m_mask[c] = m_mask[c] | p;
      m_end[c]  = e + PC;
      settle(e);
    end else if (off == 5'h00 || off == 5'h04 || off == 5'h08 || off == 5'h0C) begin
      old = m_data[c];
      settle(e);
      case (off)
        5'h00:   wr = wd[7:0];
        5'h04:   wr = old | p;
        5'h08:   wr = old & ~p;
        default: wr = old ^ p;
      endcase
      m_data[c] = (m_data[c] & ~m) | (wr & m);
      m_mask[c] = m_mask[c] & ~m;
    end else begin
      settle(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      settle(cyc);
      chk(tag, odata, exp_od());
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws, input string tag);
    logic        hit;
    logic [31:0] rd;
    hit = (addr[31:8] == BASE[31:8]);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    chk({tag, "/ready_pre"}, {31'd0, mem_ready}, 32'd0);
    tick();
    if (hit) model_access(cyc, addr, wd, ws, rd);
    else begin settle(cyc); rd = '0; end
    chk({tag, "/ready"}, {31'd0, mem_ready}, {31'd0, hit});
    chk({tag, "/odata"}, odata, exp_od());
    if (hit && ws == 4'b0000) chk({tag, "/rdata"}, mem_rdata, rd);
    tick();
    settle(cyc);
    mem_valid = 1'b0; mem_wstrb = '0;
    chk({tag, "/ready_post"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "/rdata_post"}, mem_rdata, 32'd0);
    chk({tag, "/odata_post"}, odata, exp_od());
  endtask

  function automatic logic [31:0] a(input int c, input logic [4:0] off);
    return BASE | (32'(c) << 5) | 32'(off);
  endfunction

  initial begin
    logic [4:0]  offs [7];
    logic [31:0] addr;
    logic [3:0]  ws;
    int          c;
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
    model_reset();

    tick(); tick();
    chk("reset/odata", odata, 32'd0);
    chk("reset/ready", {31'd0, mem_ready}, 32'd0);
    chk("reset/rdata", mem_rdata, 32'd0);
    resetn = 1'b1;
    idle(2, "reset/idle");

    bus(a(0, 5'h00), 32'h0000_00A5, 4'b0001, "wr_a5");
    chk("wr_a5/byte0", {24'd0, odata[7:0]}, 32'h0000_00A5);
    bus(a(0, 5'h00), 32'h0, 4'b0000, "rd_a5");

    bus(a(1, 5'h00), 32'h0F, 4'b1111, "ch1_init");
    bus(a(1, 5'h04), 32'h30, 4'b0001, "ch1_set");
    chk("ch1_set/val", {24'd0, odata[15:8]}, 32'h3F);
    bus(a(1, 5'h08), 32'h03, 4'b0001, "ch1_clr");
    chk("ch1_clr/val", {24'd0, odata[15:8]}, 32'h3C);
    bus(a(1, 5'h0C), 32'hFF, 4'b0001, "ch1_tgl");
    chk("ch1_tgl/val", {24'd0, odata[15:8]}, 32'hC3);
    chk("ch1_tgl/others", odata & 32'hFFFF_00FF, 32'h0000_00A5);

    bus(a(2, 5'h10), 32'h01, 4'b0001, "pulse");
    e0 = cyc - 1;
    idle(e0 + 9 - cyc, "pulse/run");
    bus(a(2, 5'h10), 32'h01, 4'b0001, "pulse_retrig");
    bus(a(2, 5'h14), 32'h0, 4'b0000, "status_busy");
    idle(e0 + 25 - cyc, "pulse/ext");
    chk("pulse/last_high", {31'd0, odata[16]}, 32'd1);
    idle(1, "pulse/drop");
    chk("pulse/dropped", {31'd0, odata[16]}, 32'd0);
    bus(a(2, 5'h14), 32'h0, 4'b0000, "status_idle");

    bus(a(3, 5'h10), 32'h01, 4'b0001, "coll_set_pulse");
    e0 = cyc - 1;
    idle(e0 + 15 - cyc, "coll_set/run");
    bus(a(3, 5'h04), 32'h01, 4'b0001, "coll_set");
    chk("coll_set/bit0", {31'd0, odata[24]}, 32'd1);
    idle(20, "coll_set/hold");
    chk("coll_set/static", {31'd0, odata[24]}, 32'd1);
    bus(a(3, 5'h10), 32'h01, 4'b0001, "coll_clr_pulse");
    e0 = cyc - 1;
    idle(e0 + 15 - cyc, "coll_clr/run");
    bus(a(3, 5'h08), 32'h01, 4'b0001, "coll_clr");
    chk("coll_clr/bit0", {31'd0, odata[24]}, 32'd0);

    bus(a(7, 5'h00), 32'hFF, 4'b1111, "dec_ch7_wr");
    bus(a(7, 5'h00), 32'h0, 4'b0000, "dec_ch7_rd");
    bus(32'h0300_0000, 32'hFF, 4'b1111, "dec_miss");
    bus(a(1, 5'h00), 32'h55, 4'b0000, "dec_nostrb");
    bus(a(0, 5'h14), 32'hFF, 4'b0001, "dec_status_wr");
    bus(a(0, 5'h18), 32'hFF, 4'b0001, "dec_bad_off");
    bus(a(0, 5'h18), 32'h0, 4'b0000, "dec_bad_rd");

    bus(a(0, 5'h10), 32'hF0, 4'b0001, "rst_pulse");
    idle(3, "rst_pulse/run");
    mem_valid = 1'b1; mem_addr = a(1, 5'h0C); mem_wdata = 32'hFF; mem_wstrb = 4'b0001;
    tick();
    chk("rst/in_ack", {31'd0, mem_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst/odata", odata, 32'd0);
    chk("rst/ready", {31'd0, mem_ready}, 32'd0);
    chk("rst/rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0; mem_wstrb = '0;
    model_reset();
    tick(); tick();
    chk("rst/held", odata, 32'd0);
    resetn = 1'b1;
    idle(PC + 2, "rst/after");
    bus(a(0, 5'h00), 32'h0000_00A5, 4'b0001, "rst/wr");
    bus(a(0, 5'h00), 32'h0, 4'b0000, "rst/rd");

    for (int n = 0; n < 200; n++) begin
      c = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      addr = a(c, offs[$urandom_range(0, 6)]);
      if ($urandom_range(0, 15) == 0) addr = addr ^ (32'h1 << $urandom_range(8, 31));
      ws = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      bus(addr, $urandom, ws, "rand");
      idle(($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(0, 3)), "rand/idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
